// File: rtl/qspi_psram_sim_model.sv
// QPI pseudo-SRAM model: sck/ce_n oversampled by clk, byte array in qspi_1r1w.ram.
// Optional SPI power-up mode with enter/exit-quad opcodes under `PSRAM_SPI_MODE_EN.

module qspi_psram_1r1w #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    output logic [7:0]        o_rdata
);

    logic [7:0] ram [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) ram[i_addr] <= i_wdata;
    end

    assign o_rdata = ram[i_addr];

endmodule

module qspi_psram_sim_model #(
    parameter int         ADDR_W    = 16,
    parameter int         READ_WAIT = 6,
    parameter logic [7:0] CMD_READ  = 8'hEB,
    parameter logic [7:0] CMD_WRITE = 8'h38
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       ce_n,
    inout  wire  [3:0] sio
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WAIT, S_RDATA, S_WDATA, S_IGNORE
    } state_t;

    state_t            r_state, w_next;
    logic              r_sck_d, r_ce_d;
    logic [7:0]        r_cnt, w_cnt_nx;
    logic [23:0]       r_shift, w_shift_nx, w_shift_in;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic              r_is_rd, w_rd_nx;
    logic              r_oe, w_oe_nx;
    logic [3:0]        r_dout, w_dout_nx;
    logic              r_nib, w_nib_nx;
    logic [3:0]        r_hi, w_hi_nx;
    logic              w_we;
    logic [7:0]        w_rdata, w_op;
    logic [3:0]        w_sio_in;
    logic              w_rise, w_fall, w_ce_rise, w_qpi, w_cmd_last;

    assign w_sio_in  = sio;
    assign w_rise    = sck & ~r_sck_d;
    assign w_fall    = ~sck & r_sck_d;
    assign w_ce_rise = ce_n & ~r_ce_d;

    // Driver is gated by ce_n directly so deselect releases the bus at once.
    assign sio = (r_oe && !ce_n) ? r_dout : 4'bz;

`ifdef PSRAM_SPI_MODE_EN
    logic r_qpi, r_mode, w_mode_nx;
    assign w_qpi = r_qpi;
`else
    assign w_qpi = 1'b1;
`endif

    assign w_shift_in = w_qpi ? {r_shift[19:0], w_sio_in}
                              : {r_shift[22:0], w_sio_in[0]};
    assign w_op       = w_shift_in[7:0];
    assign w_cmd_last = w_qpi ? (r_cnt == 8'd1) : (r_cnt == 8'd7);

    qspi_psram_1r1w #(.ADDR_W(ADDR_W)) qspi_1r1w (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_addr),
        .i_wdata ({r_hi, w_sio_in}),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_next     = r_state;
        w_cnt_nx   = r_cnt;
        w_shift_nx = r_shift;
        w_addr_nx  = r_addr;
        w_rd_nx    = r_is_rd;
        w_oe_nx    = r_oe;
        w_dout_nx  = r_dout;
        w_nib_nx   = r_nib;
        w_hi_nx    = r_hi;
        w_we       = 1'b0;
`ifdef PSRAM_SPI_MODE_EN
        w_mode_nx  = r_mode;
`endif
        if (ce_n) begin
            w_next   = S_IDLE;
            w_cnt_nx = '0;
            w_oe_nx  = 1'b0;
            w_nib_nx = 1'b0;
            if (w_ce_rise) w_shift_nx = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_next     = S_CMD;
                    w_cnt_nx   = '0;
                    w_shift_nx = '0;
                end
                S_CMD: if (w_rise) begin
                    w_shift_nx = w_shift_in;
                    w_cnt_nx   = r_cnt + 8'd1;
                    if (w_cmd_last) begin
                        w_cnt_nx = '0;
                        w_next   = S_IGNORE;
                        if (w_qpi && w_op == CMD_READ) begin
                            w_next  = S_ADDR;
                            w_rd_nx = 1'b1;
                        end else if (w_qpi && w_op == CMD_WRITE) begin
                            w_next  = S_ADDR;
                            w_rd_nx = 1'b0;
                        end
`ifdef PSRAM_SPI_MODE_EN
                        else if (w_qpi && w_op == 8'hF5) w_mode_nx = 1'b0;
                        else if (!w_qpi && w_op == 8'h35) w_mode_nx = 1'b1;
`endif
                    end
                end
                S_ADDR: if (w_rise) begin
                    w_shift_nx = w_shift_in;
                    w_cnt_nx   = r_cnt + 8'd1;
                    if (r_cnt == 8'd5) begin
                        w_cnt_nx  = '0;
                        w_addr_nx = w_shift_in[ADDR_W-1:0];
                        w_nib_nx  = 1'b0;
                        w_next    = r_is_rd ? S_WAIT : S_WDATA;
                    end
                end
                S_WAIT: begin
                    if (w_rise && r_cnt != 8'(READ_WAIT)) begin
                        w_cnt_nx = r_cnt + 8'd1;
                    end else if (w_fall && r_cnt == 8'(READ_WAIT)) begin
                        w_next    = S_RDATA;
                        w_oe_nx   = 1'b1;
                        w_dout_nx = w_rdata[7:4];
                        w_nib_nx  = 1'b1;
                    end
                end
                S_RDATA: if (w_fall) begin
                    if (r_nib) begin
                        w_dout_nx = w_rdata[3:0];
                        w_addr_nx = r_addr + 1'b1;
                        w_nib_nx  = 1'b0;
                    end else begin
                        w_dout_nx = w_rdata[7:4];
                        w_nib_nx  = 1'b1;
                    end
                end
                S_WDATA: if (w_rise) begin
                    if (!r_nib) begin
                        w_hi_nx  = w_sio_in;
                        w_nib_nx = 1'b1;
                    end else begin
                        w_we      = 1'b1;
                        w_addr_nx = r_addr + 1'b1;
                        w_nib_nx  = 1'b0;
                    end
                end
                S_IGNORE: ;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sck_d <= 1'b0;
            r_ce_d  <= 1'b1;
            r_cnt   <= '0;
            r_shift <= '0;
            r_addr  <= '0;
            r_is_rd <= 1'b0;
            r_oe    <= 1'b0;
            r_dout  <= '0;
            r_nib   <= 1'b0;
            r_hi    <= '0;
        end else begin
            r_state <= w_next;
            r_sck_d <= sck;
            r_ce_d  <= ce_n;
            r_cnt   <= w_cnt_nx;
            r_shift <= w_shift_nx;
            r_addr  <= w_addr_nx;
            r_is_rd <= w_rd_nx;
            r_oe    <= w_oe_nx;
            r_dout  <= w_dout_nx;
            r_nib   <= w_nib_nx;
            r_hi    <= w_hi_nx;
        end
    end

`ifdef PSRAM_SPI_MODE_EN
    // Mode change requested during a frame takes effect when ce_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_qpi  <= 1'b0;
            r_mode <= 1'b0;
        end else begin
            r_mode <= w_mode_nx;
            if (w_ce_rise) r_qpi <= r_mode;
        end
    end
`endif

endmodule

// File: tb/tb_qspi_psram_sim_model.sv
// Directed bench for qspi_psram_sim_model: vector table plus abort,
// unknown-opcode and mid-read reset sequences.

module tb_qspi_psram_sim_model;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sck;
    logic       ce_n;
    logic       m_oe;
    logic [3:0] m_dout;
    wire  [3:0] sio;

    int checks = 0;
    int errors = 0;
    logic drv_seen;

    assign sio = m_oe ? m_dout : 4'bz;

    always #5 clk = ~clk;

    qspi_psram_sim_model dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sck   (sck),
        .ce_n  (ce_n),
        .sio   (sio)
    );

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        int          n;
        logic [31:0] data;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] d, output logic [3:0] q);
        m_dout = d;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drv_seen = drv_seen | (dut.r_oe & ~ce_n);
        end
        q   = sio;
        sck = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drv_seen = drv_seen | (dut.r_oe & ~ce_n);
        end
        sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] q;
        cyc(b[7:4], q);
        cyc(b[3:0], q);
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic [3:0] q;
        for (int i = 5; i >= 0; i--) cyc(a[4*i +: 4], q);
    endtask

    task automatic begin_txn();
        m_oe = 1'b1;
        ce_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic end_txn();
        ce_n = 1'b1;
        m_oe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_write(input logic [23:0] a, input int n,
                            input logic [31:0] d);
        begin_txn();
        send_byte(8'h38);
        send_addr(a);
        for (int i = n - 1; i >= 0; i--) send_byte(d[8*i +: 8]);
        end_txn();
    endtask

    task automatic read_head(input logic [23:0] a);
        logic [3:0] q;
        begin_txn();
        send_byte(8'hEB);
        send_addr(a);
        m_oe = 1'b0;
        repeat (6) cyc(4'h0, q);
    endtask

    task automatic do_read(input logic [23:0] a, input int n,
                           output logic [31:0] d);
        logic [3:0] q;
        d = '0;
        read_head(a);
        for (int i = 0; i < 2 * n; i++) begin
            cyc(4'h0, q);
            d = {d[27:0], q};
        end
        end_txn();
    endtask

    initial begin
        logic [31:0] rd;
        logic [3:0]  q;

        vt[0] = '{8'h38, 24'h000000, 4, 32'h13000093};
        vt[1] = '{8'hEB, 24'h000000, 4, 32'h13000093};
        vt[2] = '{8'h38, 24'h000010, 2, 32'h0000A55A};
        vt[3] = '{8'hEB, 24'h000010, 2, 32'h0000A55A};
        vt[4] = '{8'h38, 24'h00FFFF, 2, 32'h00001122};
        vt[5] = '{8'hEB, 24'h00FFFF, 2, 32'h00001122};
        vt[6] = '{8'hEB, 24'h000000, 1, 32'h00000022};
        vt[7] = '{8'hEB, 24'h120010, 2, 32'h0000A55A};

        rst_n = 1'b0; sck = 1'b0; ce_n = 1'b1;
        m_oe = 1'b0; m_dout = 4'h0; drv_seen = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(dut.r_state), 32'd0);
        chk("rst_oe", 32'(dut.r_oe), 32'd0);
        chk("rst_addr", 32'(dut.r_addr), 32'd0);
        chk("rst_shift", 32'(dut.r_shift), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            drv_seen = 1'b0;
            if (vt[k].op == 8'h38) begin
                do_write(vt[k].addr, vt[k].n, vt[k].data);
                chk($sformatf("vec%0d_wr_nodrive", k), 32'(drv_seen), 32'd0);
            end else begin
                do_read(vt[k].addr, vt[k].n, rd);
                chk($sformatf("vec%0d_rdata", k), rd, vt[k].data);
                chk($sformatf("vec%0d_rd_drive", k), 32'(drv_seen), 32'd1);
            end
            chk($sformatf("vec%0d_idle", k), 32'(dut.r_state), 32'd0);
        end

        // Abort after the high nibble of the second write byte
        do_write(24'h000021, 1, 32'h5C);
        drv_seen = 1'b0;
        begin_txn();
        send_byte(8'h38);
        send_addr(24'h000020);
        send_byte(8'h77);
        cyc(4'h8, q);
        end_txn();
        chk("abort_nodrive", 32'(drv_seen), 32'd0);
        do_read(24'h000020, 2, rd);
        chk("abort_rdata", rd, 32'h0000775C);

        // Unknown opcode is ignored, next read works
        do_write(24'h000030, 1, 32'h3C);
        drv_seen = 1'b0;
        begin_txn();
        send_byte(8'h9F);
        send_addr(24'h000030);
        send_byte(8'hFF);
        chk("unk_ignore_state", 32'(dut.r_state), 32'd6);
        end_txn();
        chk("unk_nodrive", 32'(drv_seen), 32'd0);
        do_read(24'h000030, 1, rd);
        chk("unk_then_read", rd, 32'h3C);

        // Reset while the model is driving read data
        read_head(24'h000010);
        cyc(4'h0, q);
        chk("rstmid_nib0", 32'(q), 32'hA);
        cyc(4'h0, q);
        chk("rstmid_nib1", 32'(q), 32'h5);
        chk("rstmid_oe_before", 32'(dut.r_oe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_oe_async", 32'(dut.r_oe), 32'd0);
        chk("rstmid_state", 32'(dut.r_state), 32'd0);
        @(negedge clk);
        ce_n = 1'b1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstmid_idle_after", 32'(dut.r_state), 32'd0);
        do_read(24'h000000, 4, rd);
        chk("rstmid_reread", rd, 32'h22000093);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qspi_psram_sim_model.md
Name: qspi_psram_sim_model

Overview:
- Behavioural QSPI pseudo-SRAM slave used as the system-level memory model beside fpga_top. It shares the system clock and is driven over sck/ce_n/sio.
- It decodes QPI read and write commands and serves a byte-wide internal array. The array is preloadable by $readmemh through the hierarchical path qspi_1r1w.ram.
- It is a simulation model, but is written synthesizable-style: sck is oversampled with clk.

Parameters:
- ADDR_W, 16, byte-address width of the array (2^ADDR_W bytes); upper command address bits are ignored.
- READ_WAIT, 6, dummy sck cycles between the last address nibble and the first read data nibble.
- CMD_READ, 8'hEB, quad fast-read opcode.
- CMD_WRITE, 8'h38, quad write opcode.

Ports:
- clk  input  1  system clock; all state is clocked on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sck  input  1  serial clock from master; high and low phases each last at least 2 clk periods.
- ce_n  input  1  active-low chip enable; framing of one transaction.
- sio  inout  4  quad data bus; driven by the model only during the read data phase, otherwise 4'bz.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset state:
  - State is IDLE; sio output enable is 0 (bus released).
  - Nibble counter, shift register and address are 0.
  - Memory contents are not cleared.
- Edge detection:
  - sck and ce_n are registered once in clk (sck_d, ce_d).
  - A rise is sck=1 with sck_d=0; a fall is sck=0 with sck_d=1.
  - Inputs are sampled from sio on a rise; outputs change on a fall.
- Framing:
  - ce_n high at any time forces IDLE and releases sio in the same clk cycle.
  - Any partial write byte is discarded; bytes already completed remain written.
- States:
  - IDLE: on ce_n low go to CMD.
  - CMD: 2 rises, high nibble first, form the opcode.
    - CMD_READ or CMD_WRITE: go to ADDR.
    - Any other opcode: go to IGNORE.
  - ADDR: 6 rises, MSB nibble first, form a 24-bit address. Only bits [ADDR_W-1:0] are kept.
    - Read: go to WAIT.
    - Write: go to WDATA.
  - WAIT: count READ_WAIT rises. On the fall after the last wait rise, go to RDATA, enable the sio driver and present the high nibble of ram[addr].
  - RDATA: each subsequent fall presents the next nibble, high then low, per byte. After a low nibble the address increments.
  - WDATA: rises capture the high nibble, then the low nibble. On the low nibble, ram[addr] is written and the address increments.
  - IGNORE: no drive and no write until ce_n high.
- Address wrap: the increment wraps modulo 2^ADDR_W; there is no page boundary limit.
- Read-after-write: a read sees data written by any earlier completed byte, including bytes from the immediately preceding transaction.
- Rise and fall are mutually exclusive in one clk.
- A ce_n rise coincident with a sck rise: the ce_n rise wins and the sample is dropped.
- Reset mid-transaction: immediate return to IDLE and sio released.

Optional Feature:
- Macro PSRAM_SPI_MODE_EN.
- When defined:
  - The model powers up and resets into SPI mode, in which commands are shifted 1 bit per rise on sio[0], MSB first.
  - Only opcode 8'h35 (enter quad) is recognised; it switches to QPI mode at ce_n high.
  - QPI opcode 8'hF5 (exit quad) returns to SPI mode.
  - All other SPI-mode opcodes are ignored.
- When undefined: the model is permanently in QPI mode as described above, and 8'h35/8'hF5 fall into IGNORE.

Test Plan:
- Reset: hold rst_n=0 mid-read with sio driven -> sio goes z asynchronously; state IDLE after release.
- Preload: $readmemh sets ram[0..3]=13,00,00,93; issue EB, addr 000000, 6 wait cycles, 8 data nibbles -> master samples 1,3,0,0,0,0,9,3.
- Write then read: 38, addr 000010, bytes A5 5A -> ram[16]=A5, ram[17]=5A; then EB at 000010 returns A,5,5,A.
- Wrap: 38 at address 2^ADDR_W-1 with bytes 11 22 -> ram[FFFF]=11, ram[0000]=22.
- Abort: raise ce_n after the high nibble of the second write byte -> first byte written, second location unchanged; sio stays z.
- Unknown opcode 9F followed by nibbles -> no write, sio never driven; the next valid EB transaction works normally.
